// File: rtl/interfaz_alu.sv
// -----------------------------------------------------------------------------
// interfaz_alu
//
// Sequencer between a byte-serial receiver/transmitter pair and a
// combinational ALU. Three received bytes are collected in order (operand A,
// operand B, opcode) into registers that feed the ALU directly. One cycle
// later the ALU result is captured and handed to the transmitter with a
// single-cycle start pulse. The block then waits for the transmitter to
// finish before accepting the next operand set.
//
// Optional feature (macro INTF_TIMEOUT_EN):
//   When defined, an idle counter runs while waiting for operand B or the
//   opcode. If TIMEOUT_CYCLES cycles pass without a byte, the sequence is
//   abandoned, the block returns to S_A and timeout_err pulses for one cycle.
//   When undefined, no counter exists and timeout_err is tied to 0.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   rx_data     in   received byte, valid while rx_done=1
//   rx_done     in   one-cycle pulse, new byte available
//   tx_done     in   one-cycle pulse, transmitter finished current byte
//   alu_result  in   combinational ALU result
//   buf_A       out  operand A register to the ALU
//   buf_B       out  operand B register to the ALU
//   buf_Op      out  opcode register to the ALU
//   tx_data     out  byte to transmit
//   tx_start    out  one-cycle transmit request
//   overrun     out  sticky flag, a byte arrived while transmitting
//   timeout_err out  one-cycle pulse on inter-byte timeout
//   state_dbg   out  current state encoding
// -----------------------------------------------------------------------------
module interfaz_alu #(
    parameter int NBITS          = 8,
    parameter int OP_BITS        = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NBITS-1:0]   rx_data,
    input  logic               rx_done,
    input  logic               tx_done,
    input  logic [NBITS-1:0]   alu_result,
    output logic [NBITS-1:0]   buf_A,
    output logic [NBITS-1:0]   buf_B,
    output logic [OP_BITS-1:0] buf_Op,
    output logic [NBITS-1:0]   tx_data,
    output logic               tx_start,
    output logic               overrun,
    output logic               timeout_err,
    output logic [2:0]         state_dbg
);

    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;

    logic [2:0]         state_q,   state_d;
    logic [NBITS-1:0]   buf_a_q,   buf_a_d;
    logic [NBITS-1:0]   buf_b_q,   buf_b_d;
    logic [OP_BITS-1:0] buf_op_q,  buf_op_d;
    logic [NBITS-1:0]   tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               overrun_q, overrun_d;

`ifdef INTF_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    always_comb begin
        state_d    = state_q;
        buf_a_d    = buf_a_q;
        buf_b_d    = buf_b_q;
        buf_op_d   = buf_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        overrun_d  = overrun_q;
`ifdef INTF_TIMEOUT_EN
        // The counter defaults to zero, so it clears on every accepted byte,
        // on every state change and in every state that does not wait on rx.
        cnt_d      = '0;
        timeout_d  = 1'b0;
`endif

        case (state_q)
            S_A: begin
                if (rx_done) begin
                    buf_a_d = rx_data;
                    state_d = S_B;
                end
            end

            S_B: begin
                if (rx_done) begin
                    buf_b_d = rx_data;
                    state_d = S_OP;
                end
`ifdef INTF_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d   = S_A;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            S_OP: begin
                if (rx_done) begin
                    buf_op_d = rx_data[OP_BITS-1:0];
                    state_d  = S_SEND;
                end
`ifdef INTF_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d   = S_A;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            // Operands have been stable on the ALU for a full cycle, so the
            // result is sampled here and launched toward the transmitter.
            S_SEND: begin
                tx_data_d  = alu_result;
                tx_start_d = 1'b1;
                state_d    = S_WAIT;
                if (rx_done) begin
                    overrun_d = 1'b1;
                end
            end

            // A byte arriving here is dropped, even when tx_done coincides,
            // so S_A always starts from a fresh operand A.
            S_WAIT: begin
                if (rx_done) begin
                    overrun_d = 1'b1;
                end
                if (tx_done) begin
                    state_d = S_A;
                end
            end

            default: begin
                state_d = S_A;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_A;
            buf_a_q    <= '0;
            buf_b_q    <= '0;
            buf_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_a_q    <= buf_a_d;
            buf_b_q    <= buf_b_d;
            buf_op_q   <= buf_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef INTF_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign buf_A     = buf_a_q;
    assign buf_B     = buf_b_q;
    assign buf_Op    = buf_op_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign overrun   = overrun_q;
    assign state_dbg = state_q;

endmodule
